mips_multicycle_ctrl: RTL and testbench

- Moore-style main controller for the multicycle MIPS datapath: PC/IR registers, register file, single ALU, jump-target shifter, unified memory.
- Each instruction is sequenced as a chain of states. The controller issues the mux selects, write enables and ALU control for each state.
- It waits on a memory-ready handshake before fetch, load and store complete.
- Sits beside the datapath top. It takes Op/Funct from IR and Zero from the ALU.

---
 rtl/mips_ctrl_pkg.sv | 48 ++++
 rtl/mips_alu_decoder.sv | 39 +++
 rtl/mips_multicycle_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS main controller.
// Holds the controller state encodings, the opcode and funct values
// the controller recognises, the ALUOp codes passed from the sequencer
// to the ALU decoder, and the ALUControl codes driven to the ALU.
// No ports: this file is a package only.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational ALU decoder for the multicycle MIPS controller.
// Ports:
//   alu_op        in   2         operation class chosen by the sequencer
//   funct         in   6         IR[5:0], used only for R-type execution
//   alu_control   out  ALUCTL_W  operation code driven to the ALU
//   funct_illegal out  1         R-type execution with an unknown funct
module mips_alu_decoder
    import mips_ctrl_pkg::*;
#(
    parameter int ALUCTL_W = 3
) (
    input  logic [1:0]          alu_op,
    input  logic [5:0]          funct,
    output logic [ALUCTL_W-1:0] alu_control,
    output logic                funct_illegal
);

    // An unknown funct still gets a harmless add so the instruction can
    // complete; the flag lets the controller report it.
    always_comb begin
        alu_control   = ALUCTL_W'(ALU_ADD);
        funct_illegal = 1'b0;
        case (alu_op)
            ALUOP_SUB: alu_control = ALUCTL_W'(ALU_SUB);
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_control = ALUCTL_W'(ALU_ADD);
                    FN_SUB:  alu_control = ALUCTL_W'(ALU_SUB);
                    FN_AND:  alu_control = ALUCTL_W'(ALU_AND);
                    FN_OR:   alu_control = ALUCTL_W'(ALU_OR);
                    FN_SLT:  alu_control = ALUCTL_W'(ALU_SLT);
                    default: funct_illegal = 1'b1;
                endcase
            end
            default: alu_control = ALUCTL_W'(ALU_ADD);
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore-style main controller for the multicycle MIPS datapath.
// Sequences each instruction through a chain of states and drives the
// datapath mux selects, write enables and ALU control for each state.
// Ports:
//   Clk, Reset          clock and synchronous active-high reset
//   Op, Funct           IR[31:26] and IR[5:0]
//   Zero                ALU zero flag (branch decision)
//   MemReady            memory completes the current access this cycle
//   MemReq, MemWrite    memory access request and store strobe
//   IorD, IRWrite       address select and IR load enable
//   RegDst, MemtoReg    register-file write address / data selects
//   RegWrite            register-file write enable
//   ALUSrcA, ALUSrcB    ALU operand selects
//   PCSrc, PCEn         next-PC select and PC load enable
//   ALUControl          ALU operation
//   InstrDone, Illegal  final-state pulse and unsupported-instruction pulse
//   State               current state, for debug
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int STATE_W  = 4,
    parameter int ALUCTL_W = 3
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [5:0]          Op,
    input  logic [5:0]          Funct,
    input  logic                Zero,
    input  logic                MemReady,
    output logic                MemReq,
    output logic                MemWrite,
    output logic                IorD,
    output logic                IRWrite,
    output logic                RegDst,
    output logic                MemtoReg,
    output logic                RegWrite,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          PCSrc,
    output logic                PCEn,
    output logic [ALUCTL_W-1:0] ALUControl,
    output logic                InstrDone,
    output logic                Illegal,
    output logic [STATE_W-1:0]  State
);

    state_t  state_q, state_d;
    alu_op_t alu_op;
    logic    pc_write;
    logic    branch;
    logic    decode_illegal;
    logic    funct_illegal;

    mips_alu_decoder #(
        .ALUCTL_W (ALUCTL_W)
    ) u_alu_decoder (
        .alu_op        (alu_op),
        .funct         (Funct),
        .alu_control   (ALUControl),
        .funct_illegal (funct_illegal)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Memory-facing states hold until MemReady; everything else advances
    // every cycle. Unused encodings fall back to FETCH.
    always_comb begin
        state_d        = state_q;
        MemReq         = 1'b0;
        MemWrite       = 1'b0;
        IorD           = 1'b0;
        IRWrite        = 1'b0;
        RegDst         = 1'b0;
        MemtoReg       = 1'b0;
        RegWrite       = 1'b0;
        ALUSrcA        = 1'b0;
        ALUSrcB        = 2'b00;
        PCSrc          = 2'b00;
        InstrDone      = 1'b0;
        pc_write       = 1'b0;
        branch         = 1'b0;
        alu_op         = ALUOP_ADD;
        decode_illegal = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemReq   = 1'b1;
                ALUSrcB  = 2'b01;
                IRWrite  = MemReady;
                pc_write = MemReady;
                if (MemReady) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (Op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d        = S_FETCH;
                        decode_illegal = 1'b1;
                        InstrDone      = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                MemReq = 1'b1;
                IorD   = 1'b1;
                if (MemReady) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                MemtoReg  = 1'b1;
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWR: begin
                MemReq    = 1'b1;
                IorD      = 1'b1;
                MemWrite  = 1'b1;
                InstrDone = MemReady;
                if (MemReady) begin
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                alu_op  = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegDst    = 1'b1;
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA   = 1'b1;
                alu_op    = ALUOP_SUB;
                PCSrc     = 2'b01;
                branch    = 1'b1;
                InstrDone = 1'b1;
                state_d   = S_FETCH;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                PCSrc     = 2'b10;
                pc_write  = 1'b1;
                InstrDone = 1'b1;
                state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // A taken branch loads the PC only when the compare result is zero.
    assign PCEn    = pc_write | (branch & Zero);
    assign Illegal = decode_illegal | ((state_q == S_EXEC) & funct_illegal);
    assign State   = STATE_W'(state_q);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: a table of whole
// instructions run with memory always ready, hand-written sequences for
// reset and memory-wait corner cases, and randomized instruction streams
// with random memory wait counts checked against a reference model.
module tb_mips_multicycle_ctrl;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic       MemReady;
    logic       MemReq, MemWrite, IorD, IRWrite, RegDst, MemtoReg, RegWrite;
    logic       ALUSrcA, PCEn, InstrDone, Illegal;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALUControl;
    logic [3:0] State;

    int checks = 0;
    int errors = 0;
    int memwrite_cnt;
    int done_cnt;
    int q_states[$];
    int q_mrs[$];

    always #5 Clk = ~Clk;

    mips_multicycle_ctrl #(
        .STATE_W  (4),
        .ALUCTL_W (3)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Op         (Op),
        .Funct      (Funct),
        .Zero       (Zero),
        .MemReady   (MemReady),
        .MemReq     (MemReq),
        .MemWrite   (MemWrite),
        .IorD       (IorD),
        .IRWrite    (IRWrite),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .PCSrc      (PCSrc),
        .PCEn       (PCEn),
        .ALUControl (ALUControl),
        .InstrDone  (InstrDone),
        .Illegal    (Illegal),
        .State      (State)
    );

    typedef struct packed {
        logic [3:0] state;
        logic       mem_req;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic       pc_en;
        logic       instr_done;
        logic       illegal;
    } obs_t;

    typedef struct {
        string             name;
        logic [5:0]        op;
        logic [5:0]        funct;
        logic              zero;
        logic [7:0][3:0]   trace;
        int                len;
    } vec_t;

    function automatic bit op_known(logic [5:0] op);
        return op inside {6'h23, 6'h2B, 6'h00, 6'h04, 6'h08, 6'h02};
    endfunction

    function automatic bit funct_known(logic [5:0] fn);
        return fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    endfunction

    // Expected ALU operation per state; -1 where the controller leaves
    // the ALU operation unspecified.
    function automatic int alu_model(int st, logic [5:0] fn);
        case (st)
            0, 1, 2, 9: return 2;
            8:          return 6;
            6: begin
                case (fn)
                    6'h20:   return 2;
                    6'h22:   return 6;
                    6'h24:   return 0;
                    6'h25:   return 1;
                    6'h2A:   return 7;
                    default: return 2;
                endcase
            end
            default: return -1;
        endcase
    endfunction

    // Per-state output table: anything not named for a state stays 0.
    function automatic obs_t out_model(int st, logic mr, logic z,
                                       logic [5:0] op, logic [5:0] fn);
        obs_t e;
        e = '0;
        e.state = 4'(st);
        case (st)
            0: begin
                e.mem_req = 1'b1; e.alu_src_b = 2'b01;
                e.ir_write = mr; e.pc_en = mr;
            end
            1: begin
                e.alu_src_b = 2'b11;
                e.illegal = !op_known(op); e.instr_done = !op_known(op);
            end
            2: begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
            3: begin e.mem_req = 1'b1; e.iord = 1'b1; end
            4: begin e.mem_to_reg = 1'b1; e.reg_write = 1'b1; e.instr_done = 1'b1; end
            5: begin
                e.mem_req = 1'b1; e.iord = 1'b1; e.mem_write = 1'b1;
                e.instr_done = mr;
            end
            6: begin e.alu_src_a = 1'b1; e.illegal = !funct_known(fn); end
            7: begin e.reg_dst = 1'b1; e.reg_write = 1'b1; e.instr_done = 1'b1; end
            8: begin
                e.alu_src_a = 1'b1; e.pc_src = 2'b01; e.pc_en = z;
                e.instr_done = 1'b1;
            end
            9: begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
            10: begin e.reg_write = 1'b1; e.instr_done = 1'b1; end
            11: begin e.pc_src = 2'b10; e.pc_en = 1'b1; e.instr_done = 1'b1; end
            default: e = '0;
        endcase
        return e;
    endfunction

    function automatic obs_t sample_dut();
        obs_t a;
        a.state      = State;
        a.mem_req    = MemReq;
        a.mem_write  = MemWrite;
        a.iord       = IorD;
        a.ir_write   = IRWrite;
        a.reg_dst    = RegDst;
        a.mem_to_reg = MemtoReg;
        a.reg_write  = RegWrite;
        a.alu_src_a  = ALUSrcA;
        a.alu_src_b  = ALUSrcB;
        a.pc_src     = PCSrc;
        a.pc_en      = PCEn;
        a.instr_done = InstrDone;
        a.illegal    = Illegal;
        return a;
    endfunction

    task automatic applyStimulus(input logic mr, input logic [5:0] op,
                                 input logic [5:0] fn, input logic z);
        MemReady = mr;
        Op       = op;
        Funct    = fn;
        Zero     = z;
        #1;
    endtask

    task automatic checkOutput(input string tag, input int st, input logic mr,
                               input logic z, input logic [5:0] op,
                               input logic [5:0] fn);
        obs_t a, e;
        int   ea;
        a = sample_dut();
        e = out_model(st, mr, z, op, fn);
        checks++;
        if (a !== e) begin
            errors++;
            $display("[TB] FAIL %s exp_state=%0d: outputs got %h required %h",
                     tag, st, a, e);
        end
        ea = alu_model(st, fn);
        if (ea >= 0) begin
            checks++;
            if (ALUControl !== 3'(ea)) begin
                errors++;
                $display("[TB] FAIL %s alu exp_state=%0d: ALUControl got %b required %b",
                         tag, st, ALUControl, 3'(ea));
            end
        end
    endtask

    task automatic advance();
        @(posedge Clk);
        #1;
    endtask

    task automatic push_state(input int st, input int lows);
        for (int i = 0; i < lows; i++) begin
            q_states.push_back(st);
            q_mrs.push_back(0);
        end
        q_states.push_back(st);
        q_mrs.push_back((st == 0 || st == 3 || st == 5) ? 1 : int'($urandom_range(0, 1)));
    endtask

    // Step list of one instruction by class, with the requested number of
    // not-ready cycles before fetch and the data access complete.
    task automatic build_seq(input logic [5:0] op, input int low_fetch,
                             input int low_mem);
        q_states.delete();
        q_mrs.delete();
        push_state(0, low_fetch);
        push_state(1, 0);
        case (op)
            6'h23: begin push_state(2, 0); push_state(3, low_mem); push_state(4, 0); end
            6'h2B: begin push_state(2, 0); push_state(5, low_mem); end
            6'h00: begin push_state(6, 0); push_state(7, 0); end
            6'h04: push_state(8, 0);
            6'h08: begin push_state(9, 0); push_state(10, 0); end
            6'h02: push_state(11, 0);
            default: ;
        endcase
    endtask

    task automatic run_seq(input string tag, input logic [5:0] op,
                           input logic [5:0] fn, input logic z);
        memwrite_cnt = 0;
        done_cnt     = 0;
        for (int i = 0; i < q_states.size(); i++) begin
            applyStimulus(q_mrs[i][0], op, fn, z);
            checkOutput(tag, q_states[i], q_mrs[i][0], z, op, fn);
            if (MemWrite === 1'b1) memwrite_cnt++;
            if (InstrDone === 1'b1) done_cnt++;
            advance();
        end
    endtask

    task automatic check_count(input string tag, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("[TB] FAIL %s: got %0d required %0d", tag, got, req);
        end
    endtask

    function automatic vec_t mk_vec(string name, logic [5:0] op, logic [5:0] fn,
                                    logic z, int len, int s0, int s1, int s2,
                                    int s3, int s4);
        vec_t v;
        v.name  = name;
        v.op    = op;
        v.funct = fn;
        v.zero  = z;
        v.len   = len;
        v.trace = '0;
        v.trace[0] = 4'(s0);
        v.trace[1] = 4'(s1);
        v.trace[2] = 4'(s2);
        v.trace[3] = 4'(s3);
        v.trace[4] = 4'(s4);
        return v;
    endfunction

    vec_t       vecs[12];
    logic [5:0] legal_ops[6];
    logic [5:0] legal_fns[5];

    initial begin
        vecs[0]  = mk_vec("lw",       6'h23, 6'h00, 1'b0, 5, 0, 1, 2, 3, 4);
        vecs[1]  = mk_vec("sw",       6'h2B, 6'h00, 1'b0, 4, 0, 1, 2, 5, 0);
        vecs[2]  = mk_vec("r_add",    6'h00, 6'h20, 1'b0, 4, 0, 1, 6, 7, 0);
        vecs[3]  = mk_vec("r_sub",    6'h00, 6'h22, 1'b1, 4, 0, 1, 6, 7, 0);
        vecs[4]  = mk_vec("r_and",    6'h00, 6'h24, 1'b0, 4, 0, 1, 6, 7, 0);
        vecs[5]  = mk_vec("r_or",     6'h00, 6'h25, 1'b0, 4, 0, 1, 6, 7, 0);
        vecs[6]  = mk_vec("r_slt",    6'h00, 6'h2A, 1'b0, 4, 0, 1, 6, 7, 0);
        vecs[7]  = mk_vec("r_badfn",  6'h00, 6'h3F, 1'b0, 4, 0, 1, 6, 7, 0);
        vecs[8]  = mk_vec("beq_take", 6'h04, 6'h00, 1'b1, 3, 0, 1, 8, 0, 0);
        vecs[9]  = mk_vec("beq_not",  6'h04, 6'h00, 1'b0, 3, 0, 1, 8, 0, 0);
        vecs[10] = mk_vec("addi",     6'h08, 6'h00, 1'b0, 4, 0, 1, 9, 10, 0);
        vecs[11] = mk_vec("j",        6'h02, 6'h00, 1'b0, 3, 0, 1, 11, 0, 0);
        vecs[7].name = "r_badfn";
        legal_ops = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h08, 6'h02};
        legal_fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

        // Reset held two cycles from power-up.
        Reset = 1'b1;
        applyStimulus(1'b1, 6'h00, 6'h00, 1'b0);
        advance();
        advance();
        Reset = 1'b0;
        applyStimulus(1'b1, 6'h00, 6'h00, 1'b0);
        checkOutput("reset_fetch", 0, 1'b1, 1'b0, 6'h00, 6'h00);

        // Whole instructions with memory always ready.
        for (int v = 0; v < 12; v++) begin
            q_states.delete();
            q_mrs.delete();
            for (int i = 0; i < vecs[v].len; i++) begin
                q_states.push_back(int'(vecs[v].trace[i]));
                q_mrs.push_back(1);
            end
            run_seq(vecs[v].name, vecs[v].op, vecs[v].funct, vecs[v].zero);
            check_count({vecs[v].name, "_done_pulses"}, done_cnt, 1);
        end
        applyStimulus(1'b1, 6'h00, 6'h00, 1'b0);
        checkOutput("after_table", 0, 1'b1, 1'b0, 6'h00, 6'h00);

        // Store with three not-ready cycles: the strobe spans all four.
        build_seq(6'h2B, 0, 3);
        run_seq("sw_wait", 6'h2B, 6'h00, 1'b0);
        check_count("sw_wait_memwrite_cycles", memwrite_cnt, 4);
        check_count("sw_wait_done_pulses", done_cnt, 1);
        applyStimulus(1'b0, 6'h2B, 6'h00, 1'b0);
        checkOutput("sw_wait_back_fetch", 0, 1'b0, 1'b0, 6'h2B, 6'h00);
        advance();

        // Reset while a load waits on memory.
        q_states = '{0, 1, 2, 3};
        q_mrs    = '{1, 1, 1, 0};
        run_seq("lw_wait", 6'h23, 6'h00, 1'b0);
        Reset = 1'b1;
        applyStimulus(1'b0, 6'h23, 6'h00, 1'b0);
        checkOutput("memrd_before_reset", 3, 1'b0, 1'b0, 6'h23, 6'h00);
        advance();
        applyStimulus(1'b0, 6'h23, 6'h00, 1'b0);
        checkOutput("memrd_reset", 0, 1'b0, 1'b0, 6'h23, 6'h00);
        Reset = 1'b0;
        advance();

        // Two-cycle reset in the middle of an R-type instruction.
        q_states = '{0, 1};
        q_mrs    = '{1, 1};
        run_seq("exec_pre", 6'h00, 6'h20, 1'b0);
        Reset = 1'b1;
        applyStimulus(1'b1, 6'h00, 6'h20, 1'b0);
        checkOutput("exec_before_reset", 6, 1'b1, 1'b0, 6'h00, 6'h20);
        advance();
        advance();
        Reset = 1'b0;
        applyStimulus(1'b1, 6'h00, 6'h20, 1'b0);
        checkOutput("exec_reset", 0, 1'b1, 1'b0, 6'h00, 6'h20);
        advance();
        applyStimulus(1'b1, 6'h00, 6'h20, 1'b0);
        checkOutput("exec_reset_decode", 1, 1'b1, 1'b0, 6'h00, 6'h20);
        advance();
        applyStimulus(1'b1, 6'h3F, 6'h20, 1'b0);
        checkOutput("exec_resume", 6, 1'b1, 1'b0, 6'h3F, 6'h20);
        Op = 6'h00;
        advance();
        applyStimulus(1'b1, 6'h00, 6'h20, 1'b0);
        checkOutput("exec_resume_wb", 7, 1'b1, 1'b0, 6'h00, 6'h20);
        advance();

        // Random instruction stream with random memory latency.
        for (int n = 0; n < 60; n++) begin
            logic [5:0] op, fn;
            logic       z;
            int         k;
            k  = int'($urandom_range(0, 6));
            op = (k == 6) ? 6'($urandom_range(0, 63)) : legal_ops[k];
            k  = int'($urandom_range(0, 5));
            fn = (k == 5) ? 6'($urandom_range(0, 63)) : legal_fns[k];
            z  = 1'($urandom_range(0, 1));
            build_seq(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            run_seq($sformatf("rand%0d_op%h", n, op), op, fn, z);
            check_count($sformatf("rand%0d_done_pulses", n), done_cnt, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
